// File: rtl/secp256k1_pkg.sv
// Shared constants for the secp256k1 field arithmetic blocks: the field prime
// and the tag width used by the shared-reducer arbiter.
package secp256k1_pkg;

   localparam logic [255:0] P_EQ =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   localparam int NUM_REQ_MAX   = 8;
   localparam int MOD_ARB_TAG_W = $clog2(NUM_REQ_MAX);

   typedef logic [MOD_ARB_TAG_W-1:0] mod_arb_tag_t;

endpackage

// File: rtl/secp256k1_mod_arb_tag_fifo.sv
// Requester-ID FIFO for operations in flight through the shared reducer.
// First-word-fall-through: the head entry is visible while not empty.
module secp256k1_mod_arb_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_push_dat,
   input  logic                     i_pop,
   output logic [W-1:0]             o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_count = wr_ptr - rd_ptr;
   assign o_head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) begin
         mem[wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (i_push && !o_full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (i_pop && !o_empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/secp256k1_mod_arb.sv
// Round-robin sharing of one in-order secp256k1 reducer among NUM_REQ engines,
// with a tag FIFO that routes each result back to the requester that issued it.
module secp256k1_mod_arb
   import secp256k1_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [NUM_REQ-1:0][511:0]         i_dat,
   input  logic [NUM_REQ-1:0]                i_val,
   output logic [NUM_REQ-1:0]                o_rdy,
   output logic [NUM_REQ-1:0][255:0]         o_dat,
   output logic [NUM_REQ-1:0]                o_val,
   input  logic [NUM_REQ-1:0]                i_rdy,
   output logic [511:0]                      o_mod_dat,
   output logic                              o_mod_val,
   input  logic                              i_mod_rdy,
   input  logic [255:0]                      i_mod_dat,
   input  logic                              i_mod_val,
   output logic                              o_mod_rdy,
   output logic [$clog2(MAX_INFLIGHT):0]     o_inflight,
   output logic                              o_err
);

   mod_arb_tag_t       ptr;
   mod_arb_tag_t       winner;
   mod_arb_tag_t       head;
   logic               any_val;
   logic [511:0]       win_dat;
   logic               load;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               head_rdy;
   logic [NUM_REQ-1:0] head_sel;

   // Lowest valid index at or above ptr wins; otherwise the lowest below ptr.
   // The second pass overrides the first, which gives the wrap-around order.
   always_comb begin
      winner  = '0;
      any_val = 1'b0;
      win_dat = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_val[k] && (k < int'(ptr))) begin
            winner  = MOD_ARB_TAG_W'(k);
            any_val = 1'b1;
            win_dat = i_dat[k];
         end
      end
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_val[k] && (k >= int'(ptr))) begin
            winner  = MOD_ARB_TAG_W'(k);
            any_val = 1'b1;
            win_dat = i_dat[k];
         end
      end
   end

   // The FIFO count is the credit counter, so a full FIFO means no credits left.
   assign load = i_rst && any_val && !fifo_full && (!o_mod_val || i_mod_rdy);

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign o_rdy[gi]    = load && (winner == MOD_ARB_TAG_W'(gi));
         assign head_sel[gi] = (head == MOD_ARB_TAG_W'(gi));
         assign o_val[gi]    = i_rst && i_mod_val && !fifo_empty && head_sel[gi];
         assign o_dat[gi]    = i_mod_dat;
      end
   endgenerate

   // An untagged result is accepted and dropped so the reducer cannot wedge.
   assign head_rdy  = |(i_rdy & head_sel);
   assign o_mod_rdy = i_rst && (fifo_empty ? i_mod_val : head_rdy);
   assign pop       = i_mod_val && o_mod_rdy && !fifo_empty;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ptr       <= '0;
         o_mod_val <= 1'b0;
         o_mod_dat <= '0;
         o_err     <= 1'b0;
      end else begin
         if (load) begin
            o_mod_dat <= win_dat;
            o_mod_val <= 1'b1;
            ptr       <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
         end else if (i_mod_rdy) begin
            o_mod_val <= 1'b0;
         end
         if (i_mod_val && fifo_empty) begin
            o_err <= 1'b1;
         end
      end
   end

   secp256k1_mod_arb_tag_fifo #(
      .DEPTH (MAX_INFLIGHT),
      .W     (MOD_ARB_TAG_W)
   ) u_tag_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (load),
      .i_push_dat (winner),
      .i_pop      (pop),
      .o_head     (head),
      .o_empty    (fifo_empty),
      .o_full     (fifo_full),
      .o_count    (o_inflight)
   );

endmodule

// File: doc/secp256k1_mod_arb.md
# secp256k1_mod_arb

Round-robin arbiter that shares one `secp256k1_mod` reducer (512-bit in, 256-bit result mod p_eq) among NUM_REQ requesters. It registers the winning request into the reducer, keeps a tag FIFO of requester IDs for in-flight operations, and steers each result back to the requester that issued it. It sits between the ECDSA/point-arithmetic engines and the single shared reducer instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_INFLIGHT, 8, max accepted-but-unreturned operations; power of 2, ≥ reducer pipeline depth + 1
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_dat  in  NUM_REQ×512  request operand per requester
- i_val  in  NUM_REQ  request valid per requester
- o_rdy  out  NUM_REQ  request accepted this cycle (at most one bit set)
- o_dat  out  NUM_REQ×256  result per requester (all lanes carry the same reducer data)
- o_val  out  NUM_REQ  result valid (at most one bit set)
- i_rdy  in  NUM_REQ  result ready per requester
- o_mod_dat  out  512  operand to reducer
- o_mod_val  out  1  operand valid
- i_mod_rdy  in  1  reducer ready
- i_mod_dat  in  256  reducer result
- i_mod_val  in  1  reducer result valid
- o_mod_rdy  out  1  ready to reducer
- o_inflight  out  $clog2(MAX_INFLIGHT)+1  accepted-not-returned count
- o_err  out  1  sticky: result arrived with empty tag FIFO

## Operation
- Handshake on every port: transfer when val && rdy in the same cycle. A source holds val and data stable until the transfer.
- Winner: first i_val[k] scanning from ptr upward, modulo NUM_REQ.
- load = (!o_mod_val || i_mod_rdy) && (o_inflight < MAX_INFLIGHT) && any i_val.
- o_rdy[winner] = load. Accept:
  - o_mod_dat <= i_dat[winner], o_mod_val <= 1.
  - Push winner ID into the tag FIFO.
  - ptr <= (winner+1) mod NUM_REQ.
- No accept && i_mod_rdy: o_mod_val <= 0.
- Return path, combinational from the FIFO head ID h:
  - o_val[h] = i_mod_val && !empty.
  - o_mod_rdy = i_rdy[h] && !empty.
  - On transfer, pop.
- o_inflight: +1 on accept, −1 on return. Accept and return in the same cycle leave it unchanged.
- The reducer preserves order, so no reordering logic is required.
- i_mod_val with an empty FIFO:
  - Set o_err.
  - Drive o_mod_rdy = 1 to drain and discard the result.
  - o_err clears only on reset.
- Credit full (o_inflight == MAX_INFLIGHT): no o_rdy asserted. The held o_mod_val register still drains.

## Timing
- Reset (i_rst low, asynchronous) clears: o_mod_val, o_err, o_inflight, ptr, and the FIFO pointers. o_mod_dat <= 0. Combinational outputs (o_rdy, o_val, o_mod_rdy) are therefore 0.
- Reset mid-operation drops all in-flight tags. The reducer must be reset concurrently.
- Latency from request accept to o_mod_val: 1 cycle.
- Latency from i_mod_val to o_val: 0 cycles (combinational).
- Throughput: one accept per cycle while i_mod_rdy is high and credits remain.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0. No requester waits more than NUM_REQ−1 grants.
- Result backpressure (i_rdy[h] low) stalls only the return path. Issue continues until credits run out.

## Structure
- secp256k1_pkg gains `MOD_ARB_TAG_W = $clog2(NUM_REQ_MAX)`, with NUM_REQ_MAX = 8.
- Sub-module `secp256k1_mod_arb_tag_fifo`:
  - Sync FIFO, MAX_INFLIGHT × MOD_ARB_TAG_W, with empty/full outputs and count.
  - Same i_clk/i_rst (active-low asynchronous).
  - First-word-fall-through head.
- Arbiter, output register, and steering logic live in the top module.

## Test plan
- Single request: requester 2 sends 1<<433 → o_val[2] with o_dat = 822752465816620949324161418291805943222876982255305228346720256. o_inflight returns to 0.
- All four valid, each sending (1<<433)<<k for k = requester index:
  - Grants occur in order 0,1,2,3.
  - Each requester receives its own doubled expected value (subtract p_eq while ≥ p_eq).
- Hold all i_rdy low, all i_val high:
  - Exactly MAX_INFLIGHT = 8 accepts occur, then o_rdy stays 0 and o_inflight = 8.
  - Release i_rdy: 8 results are delivered in issue order.
- Toggle i_mod_rdy 50% at random; 10000 random requests from random requesters → every result matches the reference model and reaches the correct lane; o_err = 0.
- Force i_mod_val = 1 with an empty FIFO → o_err = 1, no o_val bit set, o_err stays 1 until i_rst pulses low.
- Assert i_rst low with 3 operations in flight → all outputs and o_inflight read 0 immediately. After release, a single request behaves as in the first scenario.
